spart_driver: RTL

//  Processor-side bus master for the SPART bus interface. Drives iocs/iorw/ioaddr/databus.

---
 rtl/spart_driver_if.sv | 10 +
 rtl/spart_driver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/spart_driver_if.sv
// SPART bus control signals (chip select, direction, register address).
// The 8-bit tristate data bus stays a plain inout port on the modules.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (output iocs, iorw, ioaddr);
    modport slave  (input  iocs, iorw, ioaddr);
endinterface

// File: rtl/spart_driver.sv
// Processor-side SPART bus master: programs the baud divisor, then echoes
// every received byte back to the transmitter, one bus cycle per state.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd650,
    parameter logic [15:0] DIV_9600  = 16'd324,
    parameter logic [15:0] DIV_19200 = 16'd162,
    parameter logic [15:0] DIV_38400 = 16'd80
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]     databus,
    output logic [7:0]     rx_byte,
    output logic           rx_valid
);

    typedef enum logic [2:0] {INIT_LO, INIT_HI, POLL_RX, READ, POLL_TX, WRITE} state_t;

    typedef struct packed {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, rw: 1'b1, addr: 2'b00, data: 8'h00};

    state_t      state_q;
    bus_t        bus_q;
    logic [1:0]  br_cfg_q;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q;
    logic [15:0] div_cur;
    logic [15:0] div_new;
    logic [7:0]  rd_data;

    function automatic logic [15:0] div_of(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return DIV_4800;
            2'b10:   return DIV_19200;
            2'b11:   return DIV_38400;
            default: return DIV_9600;
        endcase
    endfunction

    function automatic bus_t wr(input logic [1:0] addr, input logic [7:0] data);
        return '{cs: 1'b1, rw: 1'b0, addr: addr, data: data};
    endfunction

    function automatic bus_t rd(input logic [1:0] addr);
        return '{cs: 1'b1, rw: 1'b1, addr: addr, data: 8'h00};
    endfunction

    assign div_cur = div_of(br_cfg_q);
    assign div_new = div_of(br_cfg);

    // Unknown bits on a read resolve to 0 so a floating bus can't steer the FSM.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (databus[i]) rd_data[i] = 1'b1;
            else            rd_data[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_LO;
            bus_q      <= BUS_IDLE;
            br_cfg_q   <= br_cfg;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                // Out of reset the bus is idle; the first edge launches the INIT_LO cycle.
                INIT_LO: begin
                    if (!bus_q.cs) begin
                        bus_q <= wr(2'b10, div_cur[7:0]);
                    end else begin
                        bus_q   <= wr(2'b11, div_cur[15:8]);
                        state_q <= INIT_HI;
                    end
                end
                INIT_HI: begin
                    bus_q   <= rd(2'b01);
                    state_q <= POLL_RX;
                end
                POLL_RX: begin
                    if (br_cfg != br_cfg_q) begin
                        br_cfg_q <= br_cfg;
                        bus_q    <= wr(2'b10, div_new[7:0]);
                        state_q  <= INIT_LO;
                    end else if (rd_data[0]) begin
                        bus_q   <= rd(2'b00);
                        state_q <= READ;
                    end
                end
                READ: begin
                    rx_byte_q  <= rd_data;
                    rx_valid_q <= 1'b1;
                    bus_q      <= rd(2'b01);
                    state_q    <= POLL_TX;
                end
                // Baud changes wait here so the held byte always goes out.
                POLL_TX: begin
                    if (rd_data[1]) begin
                        bus_q   <= wr(2'b00, rx_byte_q);
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    bus_q   <= rd(2'b01);
                    state_q <= POLL_RX;
                end
                default: begin
                    bus_q   <= BUS_IDLE;
                    state_q <= INIT_LO;
                end
            endcase
        end
    end

    assign bus.iocs   = bus_q.cs;
    assign bus.iorw   = bus_q.rw;
    assign bus.ioaddr = bus_q.addr;
    assign databus    = (bus_q.cs && !bus_q.rw) ? bus_q.data : 8'hzz;
    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;

endmodule
